gru_gate_accum: RTL and testbench

Downstream consumer of the approximate 4x4 matrix-vector multiplier in the GRU datapath. It accumulates the H-lane partial result vectors produced for successive weight tiles of one gate, adds a per-lane bias, saturates, applies a hard activation, and hands the activated gate vector to the state-update stage over a valid/ready handshake. One instance sits behind each gate's multiplier array (update, reset, candidate).

---
 rtl/gru_gate_accum.sv | 166 ++++++++++++++++
 tb/tb_gru_gate_accum.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gru_gate_accum.sv
// Gate accumulator: sums TILES partial vectors plus bias, saturates to the lane
// width, applies a hard activation and hands the vector downstream over valid/ready.
module gru_gate_accum #(
    parameter int H          = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 16,
    parameter int TILES      = 4,
    parameter int ACT        = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [0:H*DATA_WIDTH-1] in_data,
    input  logic [0:H*DATA_WIDTH-1] bias_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [0:H*DATA_WIDTH-1] out_data,
    output logic                    busy
);

    localparam int CNT_W = $clog2(TILES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TILES - 1);

    // Q3.4 constants: 1.0 = 16, 0.5 = 8
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((1 << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(-(1 << (DATA_WIDTH - 1)));
    localparam logic signed [ACC_WIDTH-1:0] ONE     = ACC_WIDTH'(16);
    localparam logic signed [ACC_WIDTH-1:0] NEG_ONE = ACC_WIDTH'(-16);
    localparam logic signed [ACC_WIDTH-1:0] HALF    = ACC_WIDTH'(8);
    localparam logic signed [ACC_WIDTH-1:0] ZERO    = '0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_ACT,
        ST_OUT
    } state_t;

    state_t state;
    state_t next_state;

    logic                          in_fire;
    logic                          out_fire;
    logic [CNT_W-1:0]              cnt;
    logic signed [ACC_WIDTH-1:0]   acc      [H];
    logic signed [ACC_WIDTH-1:0]   in_ext   [H];
    logic signed [ACC_WIDTH-1:0]   bias_ext [H];
    logic [0:H*DATA_WIDTH-1]       act_vec;

    function automatic logic [DATA_WIDTH-1:0] activate(input logic signed [ACC_WIDTH-1:0] a);
        logic signed [ACC_WIDTH-1:0] s;
        logic signed [ACC_WIDTH-1:0] y;
        s = (a > SAT_MAX) ? SAT_MAX : ((a < SAT_MIN) ? SAT_MIN : a);
        y = s;
        if (ACT == 0) begin
            y = (s >>> 2) + HALF;
            y = (y > ONE) ? ONE : ((y < ZERO) ? ZERO : y);
        end else if (ACT == 1) begin
            y = (s > ONE) ? ONE : ((s < NEG_ONE) ? NEG_ONE : s);
        end
        return y[DATA_WIDTH-1:0];
    endfunction

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_comb begin
        act_vec = '0;
        for (int m = 0; m < H; m++) begin
            in_ext[m]   = ACC_WIDTH'(signed'(in_data[m*DATA_WIDTH +: DATA_WIDTH]));
            bias_ext[m] = ACC_WIDTH'(signed'(bias_in[m*DATA_WIDTH +: DATA_WIDTH]));
            act_vec[m*DATA_WIDTH +: DATA_WIDTH] = activate(acc[m]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (in_fire) begin
                    next_state = (TILES == 1) ? ST_ACT : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (in_fire && (cnt == LAST_CNT)) begin
                    next_state = ST_ACT;
                end
            end
            ST_ACT: begin
                next_state = ST_OUT;
            end
            ST_OUT: begin
                if (out_fire) begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // in_ready is a pure function of state, forced low while reset is held
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        if (!rst && ((state == ST_IDLE) || (state == ST_ACCUM))) begin
            in_ready = 1'b1;
        end
        if (state != ST_IDLE) begin
            busy = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int m = 0; m < H; m++) begin
                acc[m] <= '0;
            end
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_fire) begin
                        for (int m = 0; m < H; m++) begin
                            acc[m] <= bias_ext[m] + in_ext[m];
                        end
                        cnt <= CNT_W'(1);
                    end
                end
                ST_ACCUM: begin
                    if (in_fire) begin
                        for (int m = 0; m < H; m++) begin
                            acc[m] <= acc[m] + in_ext[m];
                        end
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_ACT: begin
                    out_data  <= act_vec;
                    out_valid <= 1'b1;
                end
                ST_OUT: begin
                    // out_data is left untouched so it keeps its last value
                    if (out_fire) begin
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gru_gate_accum.sv
// Scoreboard bench for gru_gate_accum: five instances cover the activation
// modes, tile counts, backpressure, bubbles, mid-accumulate reset and saturation.
module tb_gru_gate_accum;

    localparam int NDUT = 5;
    localparam int VW   = 32;

    typedef logic [0:VW-1] vec_t;
    typedef struct {
        int   idx;
        vec_t data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic in_valid  [NDUT];
    logic in_ready  [NDUT];
    vec_t in_data   [NDUT];
    vec_t bias_in   [NDUT];
    logic out_valid [NDUT];
    logic out_ready [NDUT];
    vec_t out_data  [NDUT];
    logic busy      [NDUT];

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    // 0: TILES=2 sigmoid, 1: TILES=1 tanh, 2: TILES=1 none, 3: TILES=4 none, 4: TILES=64 none
    for (genvar g = 0; g < NDUT; g++) begin : gen_dut
        localparam int TG = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 1 : (g == 3) ? 4 : 64;
        localparam int AG = (g == 0) ? 0 : (g == 1) ? 1 : 2;
        gru_gate_accum #(
            .H(4), .DATA_WIDTH(8), .ACC_WIDTH(16), .TILES(TG), .ACT(AG)
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .in_valid(in_valid[g]),
            .in_ready(in_ready[g]),
            .in_data(in_data[g]),
            .bias_in(bias_in[g]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .out_data(out_data[g]),
            .busy(busy[g])
        );
    end

    function automatic vec_t mk(input int a, input int b, input int c, input int d);
        vec_t v;
        v[0:7]   = 8'(a);
        v[8:15]  = 8'(b);
        v[16:23] = 8'(c);
        v[24:31] = 8'(d);
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic pushExpected(input int idx, input vec_t d);
        exp_t e;
        e.idx  = idx;
        e.data = d;
        sb_q.push_back(e);
    endtask

    // Entered and left at posedge+1; the tile is accepted on the edge just before return
    task automatic applyStimulus(input int idx, input vec_t d, input vec_t b);
        int n;
        n = 0;
        in_valid[idx] = 1'b1;
        in_data[idx]  = d;
        bias_in[idx]  = b;
        @(negedge clk);
        while (!in_ready[idx] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("[TB] FAIL in_ready_timeout dut%0d actual=0 expected=1", idx);
        end
        @(posedge clk);
        #1;
        in_valid[idx] = 1'b0;
    endtask

    // Called right after the last tile is accepted, with out_ready high
    task automatic checkLatency(input int idx, input string tag);
        @(negedge clk);
        checkOutput({tag, "_act_valid"}, 32'(out_valid[idx]), 32'd0);
        checkOutput({tag, "_act_busy"}, 32'(busy[idx]), 32'd1);
        @(negedge clk);
        checkOutput({tag, "_out_valid"}, 32'(out_valid[idx]), 32'd1);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            for (int g = 0; g < NDUT; g++) begin
                if (out_valid[g] && out_ready[g]) begin
                    checks++;
                    if (sb_q.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL sb_unexpected dut%0d actual=%h expected=none", g, out_data[g]);
                    end else begin
                        e = sb_q.pop_front();
                        if (e.idx != g || out_data[g] !== e.data) begin
                            errors++;
                            $display("[TB] FAIL sb_data dut%0d actual=%h expected=dut%0d %h",
                                     g, out_data[g], e.idx, e.data);
                        end
                    end
                end
            end
        end
    end

    initial begin
        int n;
        rst = 1'b1;
        for (int g = 0; g < NDUT; g++) begin
            in_valid[g]  = 1'b0;
            in_data[g]   = '0;
            bias_in[g]   = '0;
            out_ready[g] = 1'b1;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_in_ready", 32'(in_ready[0]), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid[0]), 32'd0);
        checkOutput("rst_busy", 32'(busy[0]), 32'd0);
        checkOutput("rst_out_data", out_data[0], 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_in_ready", 32'(in_ready[0]), 32'd1);
        @(posedge clk);
        #1;

        // Hard sigmoid, two tiles
        pushExpected(0, mk(16, 6, 0, 8));
        applyStimulus(0, mk(16, -4, -100, 0), mk(8, 0, -100, 0));
        applyStimulus(0, mk(16, -4, -100, 0), mk(0, 0, 0, 0));
        checkLatency(0, "sig");

        // Hard tanh and passthrough, single tile
        pushExpected(1, mk(16, -16, 5, -16));
        applyStimulus(1, mk(20, -20, 5, -128), mk(0, 0, 0, 0));
        checkLatency(1, "tanh");
        pushExpected(2, mk(20, -20, 5, -128));
        applyStimulus(2, mk(20, -20, 5, -128), mk(0, 0, 0, 0));
        checkLatency(2, "pass");

        // Backpressure on the tanh instance, in_valid held high throughout
        pushExpected(1, mk(-3, 7, 16, -16));
        pushExpected(1, mk(0, 16, -16, 16));
        out_ready[1] = 1'b0;
        in_valid[1]  = 1'b1;
        in_data[1]   = mk(-3, 7, 40, -40);
        bias_in[1]   = mk(0, 0, 0, 0);
        @(negedge clk);
        checkOutput("bp_idle_ready", 32'(in_ready[1]), 32'd1);
        @(posedge clk);
        #1;
        in_data[1] = mk(0, 16, -17, 100);
        @(negedge clk);
        checkOutput("bp_act_ready", 32'(in_ready[1]), 32'd0);
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp_stall_ready", 32'(in_ready[1]), 32'd0);
            checkOutput("bp_stall_valid", 32'(out_valid[1]), 32'd1);
            checkOutput("bp_stall_data", out_data[1], mk(-3, 7, 16, -16));
        end
        @(posedge clk);
        #1;
        out_ready[1] = 1'b1;
        @(negedge clk);
        checkOutput("bp_xfer_ready", 32'(in_ready[1]), 32'd0);
        @(negedge clk);
        checkOutput("bp_next_ready", 32'(in_ready[1]), 32'd1);
        checkOutput("bp_after_valid", 32'(out_valid[1]), 32'd0);
        @(posedge clk);
        #1;
        in_valid[1] = 1'b0;
        checkLatency(1, "bp2");

        // Four tiles with a two-cycle bubble between tiles 1 and 2
        pushExpected(3, mk(25, -9, 23, 101));
        applyStimulus(3, mk(10, -10, 5, 0), mk(1, 2, 3, 4));
        applyStimulus(3, mk(20, -5, 5, -1), mk(0, 0, 0, 0));
        repeat (2) @(posedge clk);
        #1;
        applyStimulus(3, mk(-7, 3, 5, -2), mk(0, 0, 0, 0));
        applyStimulus(3, mk(1, 1, 5, 100), mk(0, 0, 0, 0));
        checkLatency(3, "bubble");

        // Reset after two of four tiles, then a clean all-ones vector
        applyStimulus(3, mk(50, 50, 50, 50), mk(9, 9, 9, 9));
        applyStimulus(3, mk(50, 50, 50, 50), mk(0, 0, 0, 0));
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rstmid_in_ready", 32'(in_ready[3]), 32'd0);
        @(negedge clk);
        checkOutput("rstmid_busy", 32'(busy[3]), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        pushExpected(3, mk(4, 4, 4, 4));
        for (int t = 0; t < 4; t++) begin
            applyStimulus(3, mk(1, 1, 1, 1), mk(0, 0, 0, 0));
        end
        checkLatency(3, "rstmid");

        // Saturation with 64 tiles, positive then negative
        pushExpected(4, mk(127, 127, 127, 127));
        applyStimulus(4, mk(127, 127, 127, 127), mk(127, 127, 127, 127));
        for (int t = 1; t < 64; t++) begin
            applyStimulus(4, mk(127, 127, 127, 127), mk(0, 0, 0, 0));
        end
        checkLatency(4, "satpos");
        @(negedge clk);
        checkOutput("hold_after_xfer", out_data[4], mk(127, 127, 127, 127));
        checkOutput("hold_valid_low", 32'(out_valid[4]), 32'd0);
        @(posedge clk);
        #1;
        pushExpected(4, mk(-128, -128, -128, -128));
        applyStimulus(4, mk(-128, -128, -128, -128), mk(-128, -128, -128, -128));
        for (int t = 1; t < 64; t++) begin
            applyStimulus(4, mk(-128, -128, -128, -128), mk(0, 0, 0, 0));
        end
        checkLatency(4, "satneg");

        n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("sb_drain", 32'(sb_q.size()), 32'd0);
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
